rs_inorder_queue: RTL and testbench

Parametrised in-order reservation station for the branch unit and other in-order functional units. Accepts renamed instructions from dispatch, tracks source-operand readiness through N CDB wakeup ports, and issues strictly from the head when both operands are ready and the FU can accept. Unlike the fixed 8-entry total-flush station, it supports selective recovery: it discards only entries younger than the mispredicted branch, by ROB age.

---
 rtl/types_pkg.sv | 52 +++++
 rtl/rs_wakeup_match.sv | 21 ++
 rtl/rs_inorder_queue.sv | 159 +++++++++++++++
 tb/tb_rs_inorder_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared dispatch/issue payload types and helpers for the in-order reservation station.
package types_pkg;

    localparam int RS_DEPTH_DEFAULT   = 8;
    localparam int WAKE_PORTS_DEFAULT = 3;
    localparam int PREG_TAG_W         = 7;
    localparam int ROB_IDX_W          = 5;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_index;
        logic [PREG_TAG_W-1:0] prd;
        logic [PREG_TAG_W-1:0] pr1;
        logic                  pr1_ready;
        logic [PREG_TAG_W-1:0] pr2;
        logic                  pr2_ready;
        logic [3:0]            fu_op;
        logic [15:0]           imm;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_index;
        logic [PREG_TAG_W-1:0] prd;
        logic [PREG_TAG_W-1:0] ps1;
        logic                  ps1_ready;
        logic [PREG_TAG_W-1:0] ps2;
        logic                  ps2_ready;
        logic [3:0]            fu_op;
        logic [15:0]           imm;
    } rs_data;

    // Distance of a ROB index from the current head, modulo the ROB size.
    function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] idx,
                                                     input logic [ROB_IDX_W-1:0] head);
        return idx - head;
    endfunction

    function automatic rs_data to_rs_data(input dispatch_pipeline_data d,
                                          input logic ps1_rdy,
                                          input logic ps2_rdy);
        rs_data r;
        r.rob_index = d.rob_index;
        r.prd       = d.prd;
        r.ps1       = d.pr1;
        r.ps1_ready = ps1_rdy;
        r.ps2       = d.pr2;
        r.ps2_ready = ps2_rdy;
        r.fu_op     = d.fu_op;
        r.imm       = d.imm;
        return r;
    endfunction

endpackage

// File: rtl/rs_wakeup_match.sv
// Combinational CDB tag comparator: hit when any valid wake port carries the given tag.
module rs_wakeup_match #(
    parameter int WAKE_PORTS = 3,
    parameter int PREG_W     = 7
) (
    input  logic [PREG_W-1:0]                 tag,
    input  logic [WAKE_PORTS-1:0][PREG_W-1:0] wake_tag,
    input  logic [WAKE_PORTS-1:0]             wake_valid,
    output logic                              hit
);

    always_comb begin
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            if (wake_valid[p] && (wake_tag[p] == tag)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_inorder_queue.sv
// In-order reservation station with CDB wakeup and selective (age-based) flush recovery.
// Optional macro RS_WAKE_BYPASS_EN lets same-cycle wakeups satisfy the head issue check.
module rs_inorder_queue
    import types_pkg::*;
#(
    parameter int DEPTH      = RS_DEPTH_DEFAULT,
    parameter int WAKE_PORTS = WAKE_PORTS_DEFAULT,
    parameter int PREG_W     = PREG_TAG_W,
    parameter int ROB_W      = ROB_IDX_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  dispatch_pipeline_data             instr,
    input  logic                              fu_rdy,
    output logic                              valid_out,
    output rs_data                            data_out,
    input  logic [WAKE_PORTS-1:0][PREG_W-1:0] wake_tag,
    input  logic [WAKE_PORTS-1:0]             wake_valid,
    input  logic [ROB_W-1:0]                  rob_head,
    input  logic                              flush,
    input  logic [ROB_W-1:0]                  flush_rob_tag,
    output logic [$clog2(DEPTH):0]            occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    rs_data            entries [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W:0]    count;

    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  hit2;
    logic              disp_hit1;
    logic              disp_hit2;

    rs_data            head_entry;
    logic              head_rdy1;
    logic              head_rdy2;
    logic              issue_fire;
    logic              dispatch_fire;

    logic [ROB_W-1:0]  fage;
    logic [DEPTH-1:0]  keep_vec;
    logic [PTR_W:0]    kept_cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        rs_wakeup_match #(.WAKE_PORTS(WAKE_PORTS), .PREG_W(PREG_W)) u_ps1 (
            .tag        (entries[i].ps1),
            .wake_tag   (wake_tag),
            .wake_valid (wake_valid),
            .hit        (hit1[i])
        );
        rs_wakeup_match #(.WAKE_PORTS(WAKE_PORTS), .PREG_W(PREG_W)) u_ps2 (
            .tag        (entries[i].ps2),
            .wake_tag   (wake_tag),
            .wake_valid (wake_valid),
            .hit        (hit2[i])
        );
    end

    // Dispatch-time capture so a wakeup coinciding with dispatch is not lost.
    rs_wakeup_match #(.WAKE_PORTS(WAKE_PORTS), .PREG_W(PREG_W)) u_disp_ps1 (
        .tag        (instr.pr1),
        .wake_tag   (wake_tag),
        .wake_valid (wake_valid),
        .hit        (disp_hit1)
    );
    rs_wakeup_match #(.WAKE_PORTS(WAKE_PORTS), .PREG_W(PREG_W)) u_disp_ps2 (
        .tag        (instr.pr2),
        .wake_tag   (wake_tag),
        .wake_valid (wake_valid),
        .hit        (disp_hit2)
    );

    assign ready_in      = (count < FULL_CNT);
    assign occupancy     = count;
    assign dispatch_fire = valid_in && ready_in && !flush;
    assign issue_fire    = (count != '0) && head_rdy1 && head_rdy2 && fu_rdy && !flush;

    always_comb begin
        head_entry = entries[head_ptr];
        head_rdy1  = entries[head_ptr].ps1_ready;
        head_rdy2  = entries[head_ptr].ps2_ready;
`ifdef RS_WAKE_BYPASS_EN
        head_rdy1  = head_rdy1 | hit1[head_ptr];
        head_rdy2  = head_rdy2 | hit2[head_ptr];
`endif
        head_entry.ps1_ready = head_rdy1;
        head_entry.ps2_ready = head_rdy2;
    end

    // Entries younger than the mispredicted branch form a contiguous run at the tail.
    always_comb begin
        fage     = rob_age(flush_rob_tag, rob_head);
        keep_vec = '0;
        kept_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (rob_age(entries[i].rob_index, rob_head) <= fage)) begin
                keep_vec[i] = 1'b1;
            end
            kept_cnt = kept_cnt + {{PTR_W{1'b0}}, keep_vec[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
            ent_valid <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (flush) begin
            ent_valid <= keep_vec;
            count     <= kept_cnt;
            tail_ptr  <= head_ptr + kept_cnt[PTR_W-1:0];
            valid_out <= 1'b0;
        end else begin
            valid_out <= issue_fire;
            if (issue_fire) begin
                data_out            <= head_entry;
                ent_valid[head_ptr] <= 1'b0;
                head_ptr            <= head_ptr + 1'b1;
            end
            if (dispatch_fire) begin
                ent_valid[tail_ptr] <= 1'b1;
                tail_ptr            <= tail_ptr + 1'b1;
            end
            unique case ({dispatch_fire, issue_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; ent_valid alone defines occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && hit1[i]) begin
                entries[i].ps1_ready <= 1'b1;
            end
            if (ent_valid[i] && hit2[i]) begin
                entries[i].ps2_ready <= 1'b1;
            end
        end
        if (dispatch_fire) begin
            entries[tail_ptr] <= to_rs_data(instr,
                                            instr.pr1_ready | disp_hit1,
                                            instr.pr2_ready | disp_hit2);
        end
    end

endmodule

// File: tb/tb_rs_inorder_queue.sv
// Directed self-checking bench for rs_inorder_queue (default parameters).
module tb_rs_inorder_queue;
    import types_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  valid_in;
    logic                  ready_in;
    dispatch_pipeline_data instr;
    logic                  fu_rdy;
    logic                  valid_out;
    rs_data                data_out;
    logic [2:0][6:0]       wake_tag;
    logic [2:0]            wake_valid;
    logic [4:0]            rob_head;
    logic                  flush;
    logic [4:0]            flush_rob_tag;
    logic [3:0]            occupancy;

    int errors = 0;
    int checks = 0;

    rs_inorder_queue dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .instr         (instr),
        .fu_rdy        (fu_rdy),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .wake_tag      (wake_tag),
        .wake_valid    (wake_valid),
        .rob_head      (rob_head),
        .flush         (flush),
        .flush_rob_tag (flush_rob_tag),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic dispatch_pipeline_data mk(input int rob, input int t1, input logic r1,
                                                 input int t2, input logic r2);
        dispatch_pipeline_data d;
        d.rob_index = 5'(rob);
        d.prd       = 7'(rob + 40);
        d.pr1       = 7'(t1);
        d.pr1_ready = r1;
        d.pr2       = 7'(t2);
        d.pr2_ready = r2;
        d.fu_op     = 4'h3;
        d.imm       = 16'(rob * 3);
        return d;
    endfunction

    initial begin
        reset = 1'b1; valid_in = 1'b0; instr = '0; fu_rdy = 1'b0;
        wake_tag = '0; wake_valid = '0; rob_head = '0; flush = 1'b0; flush_rob_tag = '0;
        tick(); tick();
        chk("rst_occ", occupancy, 0);
        chk("rst_vout", valid_out, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_rdy", ready_in, 1);
        reset = 1'b0;

        // Fill with FU stalled, then drain in order
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; instr = mk(i, 1, 1'b1, 2, 1'b1);
            tick();
        end
        chk("fill_occ", occupancy, 8);
        chk("fill_rdy", ready_in, 0);
        chk("fill_vout", valid_out, 0);
        instr = mk(9, 1, 1'b1, 2, 1'b1);
        tick();
        chk("full_drop_occ", occupancy, 8);
        fu_rdy = 1'b1; instr = mk(20, 1, 1'b1, 2, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("full_issue_occ", occupancy, 7);
        chk("drain_v0", valid_out, 1);
        chk("drain_rob0", data_out.rob_index, 0);
        chk("drain_prd0", data_out.prd, 40);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("drain_v", valid_out, 1);
            chk("drain_rob", data_out.rob_index, i);
        end
        tick();
        chk("drain_end_v", valid_out, 0);
        chk("drain_end_occ", occupancy, 0);
        chk("drain_hold_rob", data_out.rob_index, 7);

        // In-order wakeup: younger ready entry must wait behind head
        fu_rdy = 1'b0;
        valid_in = 1'b1; instr = mk(8, 12, 1'b0, 3, 1'b1); tick();
        instr = mk(9, 4, 1'b1, 5, 1'b1); tick();
        valid_in = 1'b0; fu_rdy = 1'b1;
        tick();
        chk("wk_blocked_v", valid_out, 0);
        chk("wk_blocked_occ", occupancy, 2);
        wake_valid[2] = 1'b1; wake_tag[2] = 7'd12;
        tick();
        wake_valid = '0;
`ifdef RS_WAKE_BYPASS_EN
        chk("wk_byp_v", valid_out, 1);
        chk("wk_byp_rob", data_out.rob_index, 8);
        chk("wk_byp_r1", data_out.ps1_ready, 1);
        tick();
        chk("wk_second_v", valid_out, 1);
        chk("wk_second_rob", data_out.rob_index, 9);
        tick();
        chk("wk_done_v", valid_out, 0);
`else
        chk("wk_edge_v", valid_out, 0);
        tick();
        chk("wk_head_v", valid_out, 1);
        chk("wk_head_rob", data_out.rob_index, 8);
        chk("wk_head_r1", data_out.ps1_ready, 1);
        tick();
        chk("wk_second_v", valid_out, 1);
        chk("wk_second_rob", data_out.rob_index, 9);
        tick();
        chk("wk_done_v", valid_out, 0);
`endif
        chk("wk_done_occ", occupancy, 0);

        // Wakeup coinciding with dispatch
        fu_rdy = 1'b0;
        valid_in = 1'b1; instr = mk(10, 5, 1'b1, 20, 1'b0);
        wake_valid[0] = 1'b1; wake_tag[0] = 7'd20;
        tick();
        valid_in = 1'b0; wake_valid = '0;
        tick();
        chk("dwk_occ", occupancy, 1);
        chk("dwk_stall_v", valid_out, 0);
        fu_rdy = 1'b1;
        tick();
        chk("dwk_v", valid_out, 1);
        chk("dwk_rob", data_out.rob_index, 10);
        chk("dwk_r2", data_out.ps2_ready, 1);
        tick();
        chk("dwk_end_occ", occupancy, 0);

        // Selective flush around ROB wrap
        fu_rdy = 1'b0; rob_head = 5'd30;
        valid_in = 1'b1;
        instr = mk(30, 1, 1'b1, 2, 1'b1); tick();
        instr = mk(31, 1, 1'b1, 2, 1'b1); tick();
        instr = mk(0, 1, 1'b1, 2, 1'b1); tick();
        instr = mk(1, 1, 1'b1, 2, 1'b1); tick();
        instr = mk(2, 1, 1'b1, 2, 1'b1); tick();
        valid_in = 1'b0;
        chk("sf_pre_occ", occupancy, 5);
        flush = 1'b1; flush_rob_tag = 5'd31;
        tick();
        flush = 1'b0;
        chk("sf_occ", occupancy, 2);
        chk("sf_v", valid_out, 0);
        valid_in = 1'b1; instr = mk(3, 1, 1'b1, 2, 1'b1); tick();
        valid_in = 1'b0;
        chk("sf_redisp_occ", occupancy, 3);
        fu_rdy = 1'b1;
        tick();
        chk("sf_i0", data_out.rob_index, 30);
        tick();
        chk("sf_i1", data_out.rob_index, 31);
        tick();
        chk("sf_i2_v", valid_out, 1);
        chk("sf_i2", data_out.rob_index, 3);
        tick();
        chk("sf_end_v", valid_out, 0);
        chk("sf_end_occ", occupancy, 0);

        // Flush colliding with dispatch and an issuable head
        fu_rdy = 1'b0; rob_head = 5'd0;
        valid_in = 1'b1;
        instr = mk(5, 1, 1'b1, 2, 1'b1); tick();
        instr = mk(6, 1, 1'b1, 2, 1'b1); tick();
        fu_rdy = 1'b1; instr = mk(7, 1, 1'b1, 2, 1'b1);
        flush = 1'b1; flush_rob_tag = 5'd5;
        tick();
        flush = 1'b0; valid_in = 1'b0;
        chk("fc_v", valid_out, 0);
        chk("fc_occ", occupancy, 1);
        tick();
        chk("fc_head_v", valid_out, 1);
        chk("fc_head_rob", data_out.rob_index, 5);
        tick();
        chk("fc_end_v", valid_out, 0);
        chk("fc_end_occ", occupancy, 0);

        // Streaming dispatch/issue pairs across pointer wrap
        fu_rdy = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr = mk(i, 1, 1'b1, 2, 1'b1);
            tick();
            chk("wrap_occ", occupancy, 1);
            if (i == 0) begin
                chk("wrap_first_v", valid_out, 0);
            end else begin
                chk("wrap_v", valid_out, 1);
                chk("wrap_rob", data_out.rob_index, i - 1);
            end
        end
        valid_in = 1'b0;
        tick();
        chk("wrap_last_rob", data_out.rob_index, 19);
        tick();
        chk("wrap_end_v", valid_out, 0);
        chk("wrap_end_occ", occupancy, 0);

        // Reset mid-stream discards contents
        fu_rdy = 1'b0; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = mk(i + 10, 1, 1'b1, 2, 1'b1);
            tick();
        end
        chk("mr_pre_occ", occupancy, 3);
        fu_rdy = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; valid_in = 1'b0;
        chk("mr_occ", occupancy, 0);
        chk("mr_v", valid_out, 0);
        chk("mr_dout", data_out, 0);
        chk("mr_rdy", ready_in, 1);
        tick();
        chk("mr_after_v", valid_out, 0);
        chk("mr_after_occ", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
